// File: rtl/conware_pkg.sv
// conware_pkg: FSM state encoding, default colors and counter sizing
// shared by the conware cell scaler files.
package conware_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DRAIN,
      EMIT
   } state_t;

   localparam logic [31:0] DEF_GRID_COLOR  = 32'h00404040;
   localparam logic [31:0] DEF_BLANK_COLOR = 32'h00000000;

   // Width of a counter that must hold 0..n-1 (never narrower than 1).
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conware_line_buffer.sv
// conware_line_buffer: one row of cells, one write port and one
// combinational read port.
module conware_line_buffer
   import conware_pkg::*;
#(
   parameter  int DWIDTH = 32,
   parameter  int WIDTH  = 8,
   localparam int AW     = cnt_w(WIDTH)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DWIDTH-1:0] i_wdata,
   input  logic [AW-1:0]     i_raddr,
   output logic [DWIDTH-1:0] o_rdata
);

   logic [DWIDTH-1:0] r_mem [WIDTH];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < WIDTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/conware_cell_scaler.sv
// conware_cell_scaler: buffers one input row and replays it SCALE x SCALE.
// Define CONWARE_SCALER_GRID_EN to overlay a 1-pixel GRID_COLOR cell grid.
module conware_cell_scaler
   import conware_pkg::*;
#(
   parameter int                DWIDTH     = 32,
   parameter int                WIDTH      = 8,
   parameter int                SCALE      = 4,
   parameter logic [DWIDTH-1:0] GRID_COLOR = DWIDTH'(DEF_GRID_COLOR)
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  S_AXIS_TVALID,
   output logic                  S_AXIS_TREADY,
   input  logic [DWIDTH-1:0]     S_AXIS_TDATA,
   input  logic                  S_AXIS_TLAST,
   output logic                  M_AXIS_TVALID,
   input  logic                  M_AXIS_TREADY,
   output logic [DWIDTH-1:0]     M_AXIS_TDATA,
   output logic                  M_AXIS_TLAST,
   output logic [DWIDTH/8-1:0]   M_AXIS_TKEEP,
   output logic [DWIDTH/8-1:0]   M_AXIS_TSTRB,
   output logic                  ROW_ERR
);

   localparam int            AW        = cnt_w(WIDTH);
   localparam int            HW        = cnt_w(SCALE);
   localparam logic [AW-1:0] LAST_CELL = AW'(WIDTH - 1);
   localparam logic [HW-1:0] HMAX      = HW'(SCALE - 1);

   state_t              r_state;
   logic                r_tready;
   logic                r_tvalid;
   logic                r_tlast;
   logic [DWIDTH-1:0]   r_tdata;
   logic                r_row_err;
   logic [AW-1:0]       r_wr_idx;
   logic [AW-1:0]       r_last_idx;
   logic [AW-1:0]       r_rd_idx;
   logic [HW-1:0]       r_hcnt;
   logic [HW-1:0]       r_vcnt;

   logic                w_acc;
   logic                w_hs;
   logic                w_we;
   logic                w_start;
   logic                w_h_wrap;
   logic                w_r_wrap;
   logic                w_done;
   logic [HW-1:0]       w_nh;
   logic [AW-1:0]       w_nr;
   logic [HW-1:0]       w_nv;
   logic [AW-1:0]       w_raddr;
   logic [DWIDTH-1:0]   w_rdata;
   logic [DWIDTH-1:0]   w_first_data;
   logic [AW-1:0]       w_first_last;
   logic                w_first_tlast;
   logic                w_grid_nxt;
   logic [DWIDTH-1:0]   w_nxt_data;
   logic                w_nxt_last;

   assign w_acc = S_AXIS_TVALID && r_tready;
   assign w_hs  = r_tvalid && M_AXIS_TREADY;
   assign w_we  = w_acc && (r_state == FILL);
   assign w_start = w_acc && S_AXIS_TLAST &&
                    ((r_state == FILL) || (r_state == DRAIN));

   assign w_h_wrap = (r_hcnt == HMAX);
   assign w_r_wrap = (r_rd_idx == r_last_idx);
   assign w_done   = r_tlast && (r_vcnt == HMAX);

   assign w_nh = w_h_wrap ? '0 : r_hcnt + HW'(1);
   assign w_nr = !w_h_wrap ? r_rd_idx :
                 (w_r_wrap ? '0 : r_rd_idx + AW'(1));
   assign w_nv = (w_h_wrap && w_r_wrap) ? r_vcnt + HW'(1) : r_vcnt;

   assign w_raddr = (r_state == EMIT) ? w_nr : '0;

   // A one-cell row has its only cell still on the input bus.
   assign w_first_data = ((r_state == FILL) && (r_wr_idx == '0)) ?
                         S_AXIS_TDATA : w_rdata;
   assign w_first_last  = (r_state == FILL) ? r_wr_idx : r_last_idx;
   assign w_first_tlast = (w_first_last == '0) && (HMAX == '0);

`ifdef CONWARE_SCALER_GRID_EN
   assign w_grid_nxt = (SCALE > 1) && ((w_nh == HMAX) || (w_nv == HMAX));
`else
   assign w_grid_nxt = 1'b0;
`endif

   assign w_nxt_data = w_grid_nxt ? GRID_COLOR : w_rdata;
   assign w_nxt_last = (w_nr == r_last_idx) && (w_nh == HMAX);

   conware_line_buffer #(
      .DWIDTH (DWIDTH),
      .WIDTH  (WIDTH)
   ) u_line_buffer (
      .i_clk   (ACLK),
      .i_rst_n (ARESETN),
      .i_we    (w_we),
      .i_waddr (r_wr_idx),
      .i_wdata (S_AXIS_TDATA),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state    <= IDLE;
         r_tready   <= 1'b0;
         r_tvalid   <= 1'b0;
         r_tlast    <= 1'b0;
         r_tdata    <= DWIDTH'(DEF_BLANK_COLOR);
         r_row_err  <= 1'b0;
         r_wr_idx   <= '0;
         r_last_idx <= '0;
         r_rd_idx   <= '0;
         r_hcnt     <= '0;
         r_vcnt     <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_state  <= FILL;
               r_tready <= 1'b1;
            end
            FILL: begin
               if (w_acc) begin
                  r_wr_idx <= r_wr_idx + AW'(1);
                  if (S_AXIS_TLAST) begin
                     r_last_idx <= r_wr_idx;
                  end else if (r_wr_idx == LAST_CELL) begin
                     r_last_idx <= LAST_CELL;
                     r_row_err  <= 1'b1;
                     r_state    <= DRAIN;
                  end
               end
            end
            DRAIN: begin
            end
            EMIT: begin
               if (w_hs) begin
                  if (w_done) begin
                     r_state  <= FILL;
                     r_tvalid <= 1'b0;
                     r_tlast  <= 1'b0;
                     r_tready <= 1'b1;
                     r_wr_idx <= '0;
                     r_rd_idx <= '0;
                     r_hcnt   <= '0;
                     r_vcnt   <= '0;
                  end else begin
                     r_hcnt   <= w_nh;
                     r_rd_idx <= w_nr;
                     r_vcnt   <= w_nv;
                     r_tdata  <= w_nxt_data;
                     r_tlast  <= w_nxt_last;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase

         if (w_start) begin
            r_state  <= EMIT;
            r_tready <= 1'b0;
            r_tvalid <= 1'b1;
            r_tdata  <= w_first_data;
            r_tlast  <= w_first_tlast;
         end
      end
   end

   assign S_AXIS_TREADY = r_tready;
   assign M_AXIS_TVALID = r_tvalid;
   assign M_AXIS_TDATA  = r_tdata;
   assign M_AXIS_TLAST  = r_tlast;
   assign M_AXIS_TKEEP  = '1;
   assign M_AXIS_TSTRB  = '1;
   assign ROW_ERR       = r_row_err;

endmodule

// File: tb/tb_conware_cell_scaler.sv
// tb_conware_cell_scaler: directed bench for the conware cell scaler,
// WIDTH=8, SCALE=4.
module tb_conware_cell_scaler;

   localparam int          DW   = 32;
   localparam int          W    = 8;
   localparam int          S    = 4;
   localparam logic [31:0] GRID = 32'h00404040;

   logic          ACLK = 1'b0;
   logic          ARESETN = 1'b0;
   logic          S_AXIS_TVALID = 1'b0;
   logic          S_AXIS_TREADY;
   logic [DW-1:0] S_AXIS_TDATA = '0;
   logic          S_AXIS_TLAST = 1'b0;
   logic          M_AXIS_TVALID;
   logic          M_AXIS_TREADY = 1'b0;
   logic [DW-1:0] M_AXIS_TDATA;
   logic          M_AXIS_TLAST;
   logic [3:0]    M_AXIS_TKEEP;
   logic [3:0]    M_AXIS_TSTRB;
   logic          ROW_ERR;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [31:0]   cells [W];
   int            len;
   logic [31:0]   tx [$];
   logic [31:0]   q_data [$];
   logic          q_last [$];

   always #5 ACLK = ~ACLK;

   conware_cell_scaler #(
      .DWIDTH (DW),
      .WIDTH  (W),
      .SCALE  (S)
   ) dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .S_AXIS_TVALID (S_AXIS_TVALID),
      .S_AXIS_TREADY (S_AXIS_TREADY),
      .S_AXIS_TDATA  (S_AXIS_TDATA),
      .S_AXIS_TLAST  (S_AXIS_TLAST),
      .M_AXIS_TVALID (M_AXIS_TVALID),
      .M_AXIS_TREADY (M_AXIS_TREADY),
      .M_AXIS_TDATA  (M_AXIS_TDATA),
      .M_AXIS_TLAST  (M_AXIS_TLAST),
      .M_AXIS_TKEEP  (M_AXIS_TKEEP),
      .M_AXIS_TSTRB  (M_AXIS_TSTRB),
      .ROW_ERR       (ROW_ERR)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_data(input int k);
      logic [31:0] d;
      int j;
      j = k % (len * S);
      d = cells[j / S];
`ifdef CONWARE_SCALER_GRID_EN
      if (((j % S) == S - 1) || ((k / (len * S)) == S - 1)) d = GRID;
`endif
      return d;
   endfunction

   task automatic send_beat(input logic [31:0] d, input logic l);
      int n = 0;
      @(negedge ACLK);
      S_AXIS_TVALID = 1'b1;
      S_AXIS_TDATA  = d;
      S_AXIS_TLAST  = l;
      while (!S_AXIS_TREADY && n < 200) begin
         @(negedge ACLK);
         n++;
      end
      if (!S_AXIS_TREADY) check("s_tready_timeout", 32'(S_AXIS_TREADY), 32'd1);
      @(posedge ACLK);
   endtask

   task automatic send_row();
      for (int i = 0; i < tx.size(); i++) begin
         send_beat(tx[i], i == tx.size() - 1);
      end
      @(negedge ACLK);
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST  = 1'b0;
   endtask

   task automatic collect(input int n, input bit rnd);
      int          got = 0;
      int          cyc = 0;
      bit          stall = 1'b0;
      bit          hi = 1'b0;
      logic [31:0] sd = '0;
      logic        sl = 1'b0;
      q_data.delete();
      q_last.delete();
      while (got < n && cyc < 4000) begin
         @(negedge ACLK);
         cyc++;
         if (stall) begin
            check("stall_data", M_AXIS_TDATA, sd);
            check("stall_last", 32'(M_AXIS_TLAST), 32'(sl));
         end
         if (S_AXIS_TREADY !== 1'b0) hi = 1'b1;
         M_AXIS_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         stall = M_AXIS_TVALID && !M_AXIS_TREADY;
         sd = M_AXIS_TDATA;
         sl = M_AXIS_TLAST;
         if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            q_data.push_back(M_AXIS_TDATA);
            q_last.push_back(M_AXIS_TLAST);
            got++;
         end
      end
      check("beat_count", 32'(got), 32'(n));
      check("s_tready_in_emit", 32'(hi), 32'd0);
      @(posedge ACLK);
      #1;
      M_AXIS_TREADY = 1'b0;
   endtask

   task automatic verify();
      for (int k = 0; k < q_data.size(); k++) begin
         check($sformatf("data[%0d]", k), q_data[k], exp_data(k));
         check($sformatf("last[%0d]", k), 32'(q_last[k]),
               32'((k % (len * S)) == len * S - 1));
      end
   endtask

   task automatic check_idle();
      @(negedge ACLK);
      check("m_tvalid_after_row", 32'(M_AXIS_TVALID), 32'd0);
      check("s_tready_after_row", 32'(S_AXIS_TREADY), 32'd1);
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_s_tready"}, 32'(S_AXIS_TREADY), 32'd0);
      check({tag, "_m_tvalid"}, 32'(M_AXIS_TVALID), 32'd0);
      check({tag, "_m_tlast"}, 32'(M_AXIS_TLAST), 32'd0);
      check({tag, "_m_tdata"}, M_AXIS_TDATA, 32'd0);
      check({tag, "_row_err"}, 32'(ROW_ERR), 32'd0);
   endtask

   task automatic load_row(input logic [31:0] base, input int n);
      tx.delete();
      for (int i = 0; i < n; i++) tx.push_back(base + 32'(i));
      len = (n > W) ? W : n;
      for (int i = 0; i < W; i++) cells[i] = base + 32'(i);
   endtask

   initial begin
      // Power-on reset
      repeat (3) @(negedge ACLK);
      check_reset_outs("por");
      check("tkeep", 32'(M_AXIS_TKEEP), 32'hF);
      check("tstrb", 32'(M_AXIS_TSTRB), 32'hF);
      ARESETN = 1'b1;
      #1;
      check("tready_at_release", 32'(S_AXIS_TREADY), 32'd0);
      @(negedge ACLK);
      check("tready_after_release", 32'(S_AXIS_TREADY), 32'd1);

      // Full row 0..7
      load_row(32'd0, 8);
      send_row();
      check("first_beat_latency", 32'(M_AXIS_TVALID), 32'd1);
      collect(W * S * S, 1'b0);
      verify();
      check_idle();
      check("row_err_full", 32'(ROW_ERR), 32'd0);

      // Short row A,B,C
      tx.delete();
      tx.push_back(32'hAAAA_0001);
      tx.push_back(32'hBBBB_0002);
      tx.push_back(32'hCCCC_0003);
      len = 3;
      for (int i = 0; i < 3; i++) cells[i] = tx[i];
      send_row();
      collect(3 * S * S, 1'b0);
      verify();
      check_idle();
      check("row_err_short", 32'(ROW_ERR), 32'd0);

      // Overlength row of 11 cells
      load_row(32'h0000_0100, 11);
      send_row();
      collect(W * S * S, 1'b0);
      verify();
      check_idle();
      check("row_err_overlength", 32'(ROW_ERR), 32'd1);

      // Full row with random downstream back-pressure
      load_row(32'd0, 8);
      send_row();
      collect(W * S * S, 1'b1);
      verify();
      check_idle();
      check("row_err_sticky", 32'(ROW_ERR), 32'd1);

      // Reset at output beat 40, then a clean new row
      load_row(32'h0000_0050, 8);
      send_row();
      collect(40, 1'b0);
      ARESETN = 1'b0;
      #1;
      check_reset_outs("mid_emit_rst");
      repeat (2) @(negedge ACLK);
      check_reset_outs("held_rst");
      ARESETN = 1'b1;
      #1;
      check("tready_at_rerelease", 32'(S_AXIS_TREADY), 32'd0);
      @(negedge ACLK);
      check("tready_after_rerelease", 32'(S_AXIS_TREADY), 32'd1);
      load_row(32'h0000_0060, 8);
      send_row();
      collect(W * S * S, 1'b0);
      verify();
      check_idle();

      // All-ones row; grid shows through only in the grid build
      tx.delete();
      for (int i = 0; i < W; i++) begin
         tx.push_back(32'hFFFF_FFFF);
         cells[i] = 32'hFFFF_FFFF;
      end
      len = W;
      send_row();
      collect(W * S * S, 1'b0);
      verify();
      check_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/conware_cell_scaler.md
Name: conware_cell_scaler

Overview:
- Downstream stage of the conware core; consumes its per-row M_AXIS pixel stream.
- Buffers one row of WIDTH cells and replays each cell SCALE times horizontally and each row SCALE times vertically.
- Produces a display-sized AXI stream for the VDMA/video path.
- Single-row line buffer; input is back-pressured while a row is being emitted.

Parameters:
- DWIDTH, 32: pixel/TDATA width.
- WIDTH, 8: cells per input row (line-buffer depth).
- SCALE, 4: replication factor in both axes; legal range 1..16.
- GRID_COLOR, 32'h00404040: grid pixel value; used only with the optional feature.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- S_AXIS_TVALID  in  1  input beat valid.
- S_AXIS_TREADY  out  1  input ready.
- S_AXIS_TDATA  in  DWIDTH  input cell color.
- S_AXIS_TLAST  in  1  last cell of the input row.
- M_AXIS_TVALID  out  1  output beat valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TDATA  out  DWIDTH  output pixel.
- M_AXIS_TLAST  out  1  last pixel of an output row.
- M_AXIS_TKEEP  out  DWIDTH/8  all ones.
- M_AXIS_TSTRB  out  DWIDTH/8  all ones.
- ROW_ERR  out  1  sticky overlength-row flag.

Behaviour:
- Clocking and reset (decided): single clock ACLK; ARESETN is asynchronous, active-low.
- Reset values: S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, ROW_ERR=0, all counters 0, state IDLE.
- FSM states: IDLE, FILL, DRAIN, EMIT.
- IDLE -> FILL: unconditional on the first clock after reset release. TREADY rises that cycle.
- FILL: TREADY=1. Each accepted beat writes buf[wr_idx] and increments wr_idx.
  - Accepted beat with TLAST=1: row_len=wr_idx+1 -> EMIT.
  - Accepted beat with wr_idx==WIDTH-1 and TLAST=0: row_len=WIDTH; set ROW_ERR -> DRAIN.
- DRAIN: TREADY=1; beats are discarded until an accepted TLAST -> EMIT.
- EMIT: TREADY=0. Output data = buf[rd_idx]. Counters:
  - hcnt: 0..SCALE-1.
  - rd_idx: 0..row_len-1.
  - vcnt: 0..SCALE-1.
- EMIT counter advance, on each M handshake only:
  - hcnt increments; at SCALE-1 it wraps and rd_idx increments.
  - When rd_idx wraps at row_len-1, vcnt increments.
  - M_AXIS_TLAST=1 exactly when rd_idx==row_len-1 and hcnt==SCALE-1.
  - Handshake with TLAST and vcnt==SCALE-1: leave EMIT for FILL, TVALID=0 next cycle, wr_idx=0.
- Outputs are registered:
  - First M beat is valid the cycle after the last accepted input beat.
  - Output throughput is one pixel per cycle while TREADY=1.
  - TDATA/TLAST hold stable while TVALID=1 and TREADY=0.
- Latency: full row of row_len cells yields row_len*SCALE*SCALE output beats and SCALE TLASTs. Empty rows are impossible, since TLAST is always accepted with data.
- SCALE=1 is a pass-through with one row of store-and-forward delay.
- ROW_ERR clears only on reset.
- Reset mid-EMIT or mid-FILL: all state is abandoned immediately. TVALID drops asynchronously. The partial row is lost; no resume.

Optional Feature:
- Macro: CONWARE_SCALER_GRID_EN.
- Defined: any output pixel with hcnt==SCALE-1 or vcnt==SCALE-1 is replaced by GRID_COLOR, drawing a 1-pixel cell grid. Ignored when SCALE==1.
- Undefined: no substitution; GRID_COLOR is unused. Beat counts and TLAST are identical either way.

Decomposition:
- Package conware_pkg: FSM state enum (IDLE, FILL, DRAIN, EMIT), default color constants, a clog2-based counter-width function.
- One sub-module, conware_line_buffer: WIDTH x DWIDTH register array with one write port and one combinational read port.
- Counter and FSM logic stays in the top module.

Test Plan:
- WIDTH=8, SCALE=4, 8 beats 0..7 with TLAST on beat 7, TREADY=1 -> 128 beats. Row r pixel p = (p/4). TLAST on beats 31, 63, 95, 127. S_AXIS_TREADY low throughout EMIT.
- Short row: 3 beats A,B,C with TLAST on C -> 48 beats, row pattern AAAABBBBCCCC, 4 TLASTs. ROW_ERR=0.
- Overlength: 11 beats, TLAST on 11th -> beats 9-11 dropped, 128 beats from cells 0..7, ROW_ERR=1 and sticky.
- Random M_AXIS_TREADY (50%) on the first test's row -> identical sequence. TDATA/TLAST unchanged across every stalled cycle. No beat lost or duplicated.
- Assert ARESETN low at output beat 40, release, send a new row -> all outputs 0 during reset. TREADY=1 one cycle after release. New row emitted cleanly, starting at vcnt=0.
- With CONWARE_SCALER_GRID_EN, SCALE=4, all-0xFFFFFFFF row -> every 4th pixel and every 4th row = 0x00404040. Others 0xFFFFFFFF.
